regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Write-side master for the processor's 32×32 register file. Merges write-back requests from the ALU path and the load-return path into the register file's single write port (`write_reg`, `write_data`, `regWrite`). Load results are buffered in a small FIFO, and younger ALU writes squash stale buffered loads to the same register. An optional forwarding lookup lets the decode stage see buffered values that have not yet been committed.

## Interface
Parameters:
- `DEPTH`, 4: load-return FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, 8: consecutive cycles a non-empty FIFO may lose arbitration before the ALU is back-pressured.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous reset, active-low.
- `alu_valid`, in, 1: ALU write-back request.
- `alu_ready`, out, 1: arbiter accepts the ALU request this cycle.
- `alu_reg`, in, 5: ALU destination register.
- `alu_data`, in, 32: ALU result.
- `mem_valid`, in, 1: load-return request.
- `mem_ready`, out, 1: FIFO can accept a load-return this cycle.
- `mem_reg`, in, 5: load destination register.
- `mem_data`, in, 32: load data.
- `write_reg`, out, 5: to register file.
- `write_data`, out, 32: to register file.
- `regWrite`, out, 1: to register file.
- `chk_reg_1`, in, 5: forwarding lookup address, port 1.
- `chk_reg_2`, in, 5: forwarding lookup address, port 2.
- `chk_hit_1`, out, 1: a pending buffered write exists for `chk_reg_1`.
- `chk_hit_2`, out, 1: a pending buffered write exists for `chk_reg_2`.
- `chk_data_1`, out, 32: newest pending data for `chk_reg_1`.
- `chk_data_2`, out, 32: newest pending data for `chk_reg_2`.
- `fifo_count`, out, $clog2(DEPTH)+1: occupancy, for debug and verification.

## Operation
- **Handshake:** a transfer occurs when `valid && ready` are both high at a rising edge. Senders hold `reg`/`data` stable while `valid && !ready`.
- **Register 0:** any request with destination register 0 is accepted (handshake completes) but discarded. It is never enqueued and never issued.
- **FIFO entry:** `{valid, reg, data}`. `mem_ready = (count < DEPTH)`. Enqueue at tail on a mem transfer.
- **Arbitration each cycle (priority order):**
  - **FORCE:** `starve_cnt == STARVE_LIMIT` and FIFO non-empty.
    - `alu_ready = 0`.
    - Head is popped; if head valid, it is issued.
    - `starve_cnt` clears to 0.
  - **ALU:** `alu_valid` with `alu_reg != 0`.
    - `alu_ready = 1`; ALU write is issued.
    - Every FIFO entry with `reg == alu_reg` (including one enqueued the same cycle) has its valid cleared, because the ALU result is younger.
    - FIFO non-empty: `starve_cnt` increments, saturating at `STARVE_LIMIT`. FIFO empty: `starve_cnt` clears.
  - **DRAIN:** otherwise, if FIFO non-empty, the head is popped. A valid head is issued; an invalid (squashed) head is popped silently. `starve_cnt` clears.
  - `alu_ready = 1` whenever not in FORCE.
- **Issue:** registered. `regWrite`, `write_reg`, `write_data` are loaded at the edge. With no issue, `regWrite = 0` and address/data hold their previous values.
- **Simultaneous push and pop:** allowed. Count is unchanged. When full, `mem_ready` stays 0 that cycle even if a pop occurs (no bypass).
- **Forwarding (`WB_FORWARD_EN`):** combinational. Hit means a valid entry with matching, nonzero reg; data comes from the newest such entry. A lookup of register 0 never hits. Lookup does not see an ALU write issued in the same cycle.
- **Pointers:** wrap modulo `DEPTH`; count saturates at `DEPTH` by construction.

## Timing
- **Reset** (`rst_n = 0` at edge), outputs:
  - `regWrite = 0`, `write_reg = 0`, `write_data = 0`.
  - FIFO empty, all entries invalid; `starve_cnt = 0`.
  - `fifo_count = 0`, `mem_ready = 1`, `alu_ready = 1`.
  - `chk_hit_* = 0`, `chk_data_* = 0`.
- **Reset mid-operation:** buffered loads are lost; no write is issued in the reset cycle or the cycle after.
- **Latency:**
  - ALU request to `regWrite` high: 1 cycle.
  - Load-return into an empty FIFO with no ALU traffic: enqueue at edge N, issue at N+1, `regWrite` visible after edge N+1, i.e. 2 cycles.
- **Throughput:** at most one register-file write per cycle.
- **Forward visibility:** a load enqueued at edge N is visible on `chk_*` from after edge N until its pop edge.

## Configuration
- `WB_FORWARD_EN` defined: forwarding lookup logic is built as described.
- Undefined:
  - `chk_hit_*` tied 0 and `chk_data_*` tied 0; no match comparators.
  - Squash logic stays, since it is required for correctness.

## Structure
- **Package `wb_pkg`:**
  - `REG_ADDR_W = 5`, `REG_DATA_W = 32`.
  - `wb_entry_t` struct `{logic valid; logic [4:0] rd; logic [31:0] data;}`.
  - Enum `wb_sel_t {WB_NONE, WB_ALU, WB_DRAIN, WB_FORCE}`.
- **Sub-module `wb_fifo`:** circular buffer with per-entry squash-by-register input and a newest-match lookup port. The arbiter top holds selection, the starvation counter and the output registers.

## Test plan
- **Reset values:** after `rst_n` low 2 cycles, all outputs match the reset values above. Then `alu_valid`, `alu_reg = 3`, `alu_data = 0x55` → next cycle `regWrite = 1`, `write_reg = 3`, `write_data = 0x55`.
- **Load path:** `mem_valid` with reg 7 = 0xAB, no ALU traffic → `fifo_count = 1` for one cycle, `chk_reg_1 = 7` gives hit/0xAB, then a write of 7/0xAB is issued, `fifo_count = 0`.
- **Squash:** enqueue load reg 5 = 0x11, then ALU reg 5 = 0x22 on the next cycle → only 5/0x22 is written. The squashed entry pops with `regWrite = 0`.
- **Full FIFO:** 4 loads while the ALU is continuously valid → `mem_ready = 0` at count 4. After `STARVE_LIMIT = 8` ALU cycles, `alu_ready = 0` for one cycle and the head load is issued.
- **Register 0:** ALU and load requests to reg 0 → handshakes complete, `regWrite` never asserts, `fifo_count` stays 0, `chk_reg_1 = 0` never hits.
- **Reset mid-operation:** reset with 3 entries buffered → `fifo_count = 0`, and no stale writes are issued afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register-file write arbiter: widths, FIFO entry layout
// and the per-cycle arbitration selection.
package wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_DRAIN,
        WB_FORCE
    } wb_sel_t;
endpackage

// File: rtl/wb_fifo.sv
// Load-return circular buffer with squash-by-register and, when WB_FORWARD_EN
// is defined, a two-port newest-valid-match lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [REG_ADDR_W-1:0]         push_rd,
    input  logic [REG_DATA_W-1:0]         push_data,
    input  logic                          pop,
    input  logic                          squash_en,
    input  logic [REG_ADDR_W-1:0]         squash_rd,
    output logic                          head_valid,
    output logic [REG_ADDR_W-1:0]         head_rd,
    output logic [REG_DATA_W-1:0]         head_data,
    output logic [$clog2(DEPTH):0]        count
`ifdef WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0]         lk_rd_1,
    input  logic [REG_ADDR_W-1:0]         lk_rd_2,
    output logic                          lk_hit_1,
    output logic                          lk_hit_2,
    output logic [REG_DATA_W-1:0]         lk_data_1,
    output logic [REG_DATA_W-1:0]         lk_data_2
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       ent [DEPTH];
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;

    assign head_valid = ent[head_ptr].valid;
    assign head_rd    = ent[head_ptr].rd;
    assign head_data  = ent[head_ptr].data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            // A younger ALU write makes every buffered load to that register stale.
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && ent[i].rd == squash_rd) ent[i].valid <= 1'b0;
            end
            if (pop) begin
                ent[head_ptr].valid <= 1'b0;
                head_ptr <= head_ptr + 1'b1;
            end
            if (push) begin
                ent[tail_ptr].valid <= !(squash_en && push_rd == squash_rd);
                ent[tail_ptr].rd    <= push_rd;
                ent[tail_ptr].data  <= push_data;
                tail_ptr <= tail_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    logic [PW-1:0] idx;

    // Walk oldest to newest so the last match seen is the newest pending value.
    always_comb begin
        lk_hit_1  = 1'b0;
        lk_hit_2  = 1'b0;
        lk_data_1 = '0;
        lk_data_2 = '0;
        idx       = head_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PW'(i);
            if (CW'(i) < count && ent[idx].valid) begin
                if (lk_rd_1 != '0 && ent[idx].rd == lk_rd_1) begin
                    lk_hit_1  = 1'b1;
                    lk_data_1 = ent[idx].data;
                end
                if (lk_rd_2 != '0 && ent[idx].rd == lk_rd_2) begin
                    lk_hit_2  = 1'b1;
                    lk_data_2 = ent[idx].data;
                end
            end
        end
    end
`endif
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and load-return write-backs into the single register-file write
// port; forwarding lookup is built only when WB_FORWARD_EN is defined.
module regfile_write_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [REG_ADDR_W-1:0]   alu_reg,
    input  logic [REG_DATA_W-1:0]   alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [REG_ADDR_W-1:0]   mem_reg,
    input  logic [REG_DATA_W-1:0]   mem_data,
    output logic [REG_ADDR_W-1:0]   write_reg,
    output logic [REG_DATA_W-1:0]   write_data,
    output logic                    regWrite,
    input  logic [REG_ADDR_W-1:0]   chk_reg_1,
    input  logic [REG_ADDR_W-1:0]   chk_reg_2,
    output logic                    chk_hit_1,
    output logic                    chk_hit_2,
    output logic [REG_DATA_W-1:0]   chk_data_1,
    output logic [REG_DATA_W-1:0]   chk_data_2,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Handshake: a transfer happens at a rising edge where valid && ready;
    // the sender holds reg/data while valid && !ready. Register 0 transfers
    // complete but are dropped.
    wb_sel_t               sel;
    logic [SW-1:0]         starve_cnt;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  head_valid;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [REG_DATA_W-1:0] head_data;

    assign fifo_empty = (fifo_count == '0);
    assign mem_ready  = (fifo_count < CW'(DEPTH));
    assign alu_ready  = (sel != WB_FORCE);
    assign push       = mem_valid && mem_ready && (mem_reg != '0);
    assign pop        = (sel == WB_FORCE) || (sel == WB_DRAIN);

    always_comb begin
        sel = WB_NONE;
        if (starve_cnt == SW'(STARVE_LIMIT) && !fifo_empty) sel = WB_FORCE;
        else if (alu_valid && alu_reg != '0)                sel = WB_ALU;
        else if (!fifo_empty)                               sel = WB_DRAIN;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_rd    (mem_reg),
        .push_data  (mem_data),
        .pop        (pop),
        .squash_en  (sel == WB_ALU),
        .squash_rd  (alu_reg),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .count      (fifo_count)
`ifdef WB_FORWARD_EN
        ,
        .lk_rd_1    (chk_reg_1),
        .lk_rd_2    (chk_reg_2),
        .lk_hit_1   (chk_hit_1),
        .lk_hit_2   (chk_hit_2),
        .lk_data_1  (chk_data_1),
        .lk_data_2  (chk_data_2)
`endif
    );

`ifndef WB_FORWARD_EN
    logic unused_chk;
    assign unused_chk = ^{chk_reg_1, chk_reg_2};
    assign chk_hit_1  = 1'b0;
    assign chk_hit_2  = 1'b0;
    assign chk_data_1 = '0;
    assign chk_data_2 = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            starve_cnt <= '0;
        end else begin
            regWrite <= 1'b0;
            case (sel)
                WB_ALU: begin
                    regWrite   <= 1'b1;
                    write_reg  <= alu_reg;
                    write_data <= alu_data;
                    if (fifo_empty)                            starve_cnt <= '0;
                    else if (starve_cnt != SW'(STARVE_LIMIT))  starve_cnt <= starve_cnt + 1'b1;
                end
                WB_FORCE, WB_DRAIN: begin
                    // A squashed head leaves the FIFO without touching the register file.
                    if (head_valid) begin
                        regWrite   <= 1'b1;
                        write_reg  <= head_rd;
                        write_data <= head_data;
                    end
                    starve_cnt <= '0;
                end
                default: starve_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle vector table plus hand-written
// starvation and mid-operation reset sequences; honours WB_FORWARD_EN.
module tb_regfile_write_arbiter;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        regWrite;
    logic [4:0]  chk_reg_1;
    logic [4:0]  chk_reg_2;
    logic        chk_hit_1;
    logic        chk_hit_2;
    logic [31:0] chk_data_1;
    logic [31:0] chk_data_2;
    logic [2:0]  fifo_count;

    regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .write_reg  (write_reg),
        .write_data (write_data),
        .regWrite   (regWrite),
        .chk_reg_1  (chk_reg_1),
        .chk_reg_2  (chk_reg_2),
        .chk_hit_1  (chk_hit_1),
        .chk_hit_2  (chk_hit_2),
        .chk_data_1 (chk_data_1),
        .chk_data_2 (chk_data_2),
        .fifo_count (fifo_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [36:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0;
        alu_reg   = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_reg   = '0;
        mem_data  = '0;
    endtask

    // Scoreboard: every issued write must match the oldest expected one.
    logic [36:0] exp_w;
    always @(posedge clk) begin
        #1;
        if (regWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, write_reg, write_data}, 64'h0);
            end else begin
                exp_w = exp_q.pop_front();
                check("write", {27'd0, write_reg, write_data}, {27'd0, exp_w});
            end
        end
    end

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic [4:0]  c1;
        logic        e_ardy;
        logic        e_mrdy;
        logic [2:0]  e_cnt;
        logic        e_hit;
        logic [31:0] e_cd;
        logic        e_wr;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
    } vec_t;

    function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                                logic mv, logic [4:0] mr, logic [31:0] md, logic [4:0] c1,
                                logic e_ardy, logic e_mrdy, logic [2:0] e_cnt,
                                logic e_hit, logic [31:0] e_cd,
                                logic e_wr, logic [4:0] e_wreg, logic [31:0] e_wdata);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md; v.c1 = c1;
        v.e_ardy = e_ardy; v.e_mrdy = e_mrdy; v.e_cnt = e_cnt;
        v.e_hit = e_hit; v.e_cd = e_cd;
        v.e_wr = e_wr; v.e_wreg = e_wreg; v.e_wdata = e_wdata;
        return v;
    endfunction

    vec_t vecs[19];
    int   idx;

    initial begin
        // Per-cycle vectors; e_cnt/e_hit/e_cd are before the edge, e_wr after it.
        vecs[0]  = mk(1, 3, 'h55, 0, 0, 0,     0, 1, 1, 0, 0, 0,     1, 3, 'h55);
        vecs[1]  = mk(0, 0, 0,    0, 0, 0,     0, 1, 1, 0, 0, 0,     0, 0, 0);
        vecs[2]  = mk(0, 0, 0,    1, 7, 'hAB,  7, 1, 1, 0, 0, 0,     0, 0, 0);
        vecs[3]  = mk(0, 0, 0,    0, 0, 0,     7, 1, 1, 1, 1, 'hAB,  1, 7, 'hAB);
        vecs[4]  = mk(0, 0, 0,    0, 0, 0,     7, 1, 1, 0, 0, 0,     0, 0, 0);
        vecs[5]  = mk(0, 0, 0,    1, 5, 'h11,  5, 1, 1, 0, 0, 0,     0, 0, 0);
        vecs[6]  = mk(1, 5, 'h22, 0, 0, 0,     5, 1, 1, 1, 1, 'h11,  1, 5, 'h22);
        vecs[7]  = mk(0, 0, 0,    0, 0, 0,     5, 1, 1, 1, 0, 0,     0, 0, 0);
        vecs[8]  = mk(0, 0, 0,    0, 0, 0,     5, 1, 1, 0, 0, 0,     0, 0, 0);
        vecs[9]  = mk(1, 0, 'h99, 1, 0, 'h77,  0, 1, 1, 0, 0, 0,     0, 0, 0);
        vecs[10] = mk(0, 0, 0,    0, 0, 0,     0, 1, 1, 0, 0, 0,     0, 0, 0);
        vecs[11] = mk(0, 0, 0,    1, 9, 'h01,  9, 1, 1, 0, 0, 0,     0, 0, 0);
        vecs[12] = mk(1, 4, 'h44, 1, 9, 'h02,  9, 1, 1, 1, 1, 'h01,  1, 4, 'h44);
        vecs[13] = mk(1, 6, 'h66, 0, 0, 0,     9, 1, 1, 2, 1, 'h02,  1, 6, 'h66);
        vecs[14] = mk(1, 9, 'h99, 1, 9, 'h03,  9, 1, 1, 2, 1, 'h02,  1, 9, 'h99);
        vecs[15] = mk(0, 0, 0,    0, 0, 0,     9, 1, 1, 3, 0, 0,     0, 0, 0);
        vecs[16] = mk(0, 0, 0,    0, 0, 0,     9, 1, 1, 2, 0, 0,     0, 0, 0);
        vecs[17] = mk(0, 0, 0,    0, 0, 0,     9, 1, 1, 1, 0, 0,     0, 0, 0);
        vecs[18] = mk(0, 0, 0,    0, 0, 0,     9, 1, 1, 0, 0, 0,     0, 0, 0);

        rst_n = 1'b0;
        drive_idle();
        chk_reg_1 = '0;
        chk_reg_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_regWrite",   regWrite,   0);
        check("rst_write_reg",  write_reg,  0);
        check("rst_write_data", write_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_mem_ready",  mem_ready,  1);
        check("rst_alu_ready",  alu_ready,  1);
        check("rst_hit",        {chk_hit_1, chk_hit_2}, 0);
        check("rst_chk_data",   {chk_data_1, chk_data_2}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
            chk_reg_1 = vecs[i].c1; chk_reg_2 = vecs[i].c1;
            #1;
            check("vec_alu_ready",  alu_ready,  vecs[i].e_ardy);
            check("vec_mem_ready",  mem_ready,  vecs[i].e_mrdy);
            check("vec_fifo_count", fifo_count, vecs[i].e_cnt);
            check("vec_hit_1",  chk_hit_1,  FWD ? vecs[i].e_hit : 1'b0);
            check("vec_data_1", chk_data_1, FWD ? vecs[i].e_cd  : 32'h0);
            check("vec_hit_2",  chk_hit_2,  FWD ? vecs[i].e_hit : 1'b0);
            check("vec_data_2", chk_data_2, FWD ? vecs[i].e_cd  : 32'h0);
            if (vecs[i].e_wr) exp_q.push_back({vecs[i].e_wreg, vecs[i].e_wdata});
            @(posedge clk);
            #1;
            check("vec_regWrite", regWrite, vecs[i].e_wr);
        end

        // Starvation: ALU always valid while four loads fill the FIFO.
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            idx = (c < 9) ? c : 9;
            alu_valid = 1'b1;
            alu_reg   = 5'(10 + idx);
            alu_data  = 32'h100 + 32'(idx);
            mem_valid = (c < 4);
            mem_reg   = 5'(20 + c);
            mem_data  = 32'hA0 + 32'(c);
            #1;
            check("starve_alu_ready", alu_ready, (c != 9));
            check("starve_mem_ready", mem_ready, (c < 4 || c == 10));
            check("starve_fifo_count", fifo_count, (c < 4) ? c : ((c == 10) ? 3 : 4));
            if (c == 9) exp_q.push_back({5'd20, 32'hA0});
            else        exp_q.push_back({5'(10 + idx), 32'h100 + 32'(idx)});
            @(posedge clk);
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            drive_idle();
            #1;
            check("drain_fifo_count", fifo_count, 4 - k);
            exp_q.push_back({5'(20 + k), 32'hA0 + 32'(k)});
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        check("drain_empty", fifo_count, 0);

        // Reset with three loads buffered.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            alu_valid = 1'b1;
            alu_reg   = 5'(1 + c);
            alu_data  = 32'h200 + 32'(c);
            mem_valid = 1'b1;
            mem_reg   = 5'(11 + c);
            mem_data  = 32'h300 + 32'(c);
            exp_q.push_back({5'(1 + c), 32'h200 + 32'(c)});
            @(posedge clk);
        end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        check("pre_reset_count", fifo_count, 3);
        @(posedge clk);
        #1;
        check("mid_rst_count",    fifo_count, 0);
        check("mid_rst_regWrite", regWrite,   0);
        check("mid_rst_mem_ready", mem_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check("post_rst_regWrite", regWrite,   0);
            check("post_rst_count",    fifo_count, 0);
        end

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
